mem_bus_arbiter: RTL and testbench

- Shares one single-port memory bus between the instruction-fetch requester (IF) and the data-access requester (MEM stage) of the 5-stage core.
- Sequences each access through a small grant FSM, returns data and acknowledge to the owner, and produces per-requester stall signals for the pipeline.
- Bounds every access with a watchdog timeout so a silent slave cannot hang the core.

---
 rtl/mem_bus_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Shares one single-port memory bus between the instruction-fetch
//            (IF) and data-access (MEM) requesters. It runs one access at a
//            time through a grant FSM, returns ack/rdata to the owner, makes
//            per-requester stalls, and ends an access on a watchdog timeout.
// Options  : define ARB_RR_EN for round-robin arbitration. Without it, MEM
//            has fixed priority over IF.
// Revision : 1.0  initial release
// ============================================================================
module mem_bus_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   // instruction-fetch requester
   input  logic                  if_req_i,
   input  logic [ADDR_W-1:0]     if_addr_i,
   output logic [DATA_W-1:0]     if_rdata_o,
   output logic                  if_ack_o,
   output logic                  if_err_o,
   // data-access requester
   input  logic                  mem_req_i,
   input  logic                  mem_we_i,
   input  logic [DATA_W/8-1:0]   mem_sel_i,
   input  logic [ADDR_W-1:0]     mem_addr_i,
   input  logic [DATA_W-1:0]     mem_wdata_i,
   output logic [DATA_W-1:0]     mem_rdata_o,
   output logic                  mem_ack_o,
   output logic                  mem_err_o,
   // shared bus
   output logic                  bus_cyc_o,
   output logic                  bus_stb_o,
   output logic                  bus_we_o,
   output logic [DATA_W/8-1:0]   bus_sel_o,
   output logic [ADDR_W-1:0]     bus_addr_o,
   output logic [DATA_W-1:0]     bus_wdata_o,
   input  logic [DATA_W-1:0]     bus_rdata_i,
   input  logic                  bus_ack_i,
   // pipeline stalls
   output logic                  if_stall_o,
   output logic                  mem_stall_o
);

   // r_cnt counts ack-less grant cycles already completed, so the watchdog
   // fires during the TIMEOUT-th grant cycle when r_cnt reaches TIMEOUT-1.
   localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GNT_IF  = 2'd1,
      S_GNT_MEM = 2'd2
   } state_t;

   state_t              r_state;
   logic [7:0]          r_cnt;
   logic [DATA_W-1:0]   r_if_rdata;
   logic [DATA_W-1:0]   r_mem_rdata;

   logic                w_in_if;
   logic                w_in_mem;
   logic                w_expire;
   logic                w_pick_mem;
   logic                w_pick_if;

   assign w_in_if  = (r_state == S_GNT_IF);
   assign w_in_mem = (r_state == S_GNT_MEM);
   // Ack beats the watchdog when both land in the same cycle.
   assign w_expire = ~bus_ack_i & (r_cnt == c_TO_LAST);

   assign if_ack_o  = w_in_if  & bus_ack_i;
   assign if_err_o  = w_in_if  & w_expire;
   assign mem_ack_o = w_in_mem & bus_ack_i;
   assign mem_err_o = w_in_mem & w_expire;

   // The owner sees live bus data on its ack cycle; otherwise the last value is held.
   assign if_rdata_o  = if_ack_o  ? bus_rdata_i : r_if_rdata;
   assign mem_rdata_o = mem_ack_o ? bus_rdata_i : r_mem_rdata;

   assign if_stall_o  = if_req_i  & ~if_ack_o  & ~if_err_o;
   assign mem_stall_o = mem_req_i & ~mem_ack_o & ~mem_err_o;

`ifdef ARB_RR_EN
   // 1 = IF is favoured on a tie, 0 = MEM is favoured (reset value).
   logic r_rr_if;
   assign w_pick_mem = mem_req_i & (~if_req_i | ~r_rr_if);
`else
   assign w_pick_mem = mem_req_i;
`endif
   assign w_pick_if  = if_req_i & ~w_pick_mem;

   // Grant FSM: latches the winner onto the bus, then waits for ack or watchdog.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         bus_cyc_o   <= 1'b0;
         bus_stb_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_sel_o   <= '0;
         bus_addr_o  <= '0;
         bus_wdata_o <= '0;
`ifdef ARB_RR_EN
         r_rr_if     <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (w_pick_mem) begin
                  r_state     <= S_GNT_MEM;
                  bus_cyc_o   <= 1'b1;
                  bus_stb_o   <= 1'b1;
                  bus_we_o    <= mem_we_i;
                  bus_sel_o   <= mem_sel_i;
                  bus_addr_o  <= mem_addr_i;
                  bus_wdata_o <= mem_wdata_i;
               end else if (w_pick_if) begin
                  r_state     <= S_GNT_IF;
                  bus_cyc_o   <= 1'b1;
                  bus_stb_o   <= 1'b1;
                  bus_we_o    <= 1'b0;
                  bus_sel_o   <= '1;
                  bus_addr_o  <= if_addr_i;
                  bus_wdata_o <= '0;
               end
            end
            S_GNT_IF, S_GNT_MEM: begin
               if (bus_ack_i || w_expire) begin
                  r_state   <= S_IDLE;
                  bus_cyc_o <= 1'b0;
                  bus_stb_o <= 1'b0;
                  r_cnt     <= '0;
`ifdef ARB_RR_EN
                  // Favour whoever did not own the access that just ended.
                  r_rr_if   <= w_in_mem;
`endif
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               bus_cyc_o <= 1'b0;
               bus_stb_o <= 1'b0;
               r_cnt     <= '0;
            end
         endcase
      end
   end

   // Read-data holding registers capture the bus on each owner ack.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_if_rdata  <= '0;
         r_mem_rdata <= '0;
      end else begin
         if (if_ack_o)  r_if_rdata  <= bus_rdata_i;
         if (mem_ack_o) r_mem_rdata <= bus_rdata_i;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Directed and randomized self-checking bench for mem_bus_arbiter.
//            It uses a transaction-level reference model for the arbitration
//            winner, ack/timeout outcome and read-data hold.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_bus_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 15;

   logic           clk;
   logic           rst_i;
   logic           if_req;
   logic [AW-1:0]  if_addr;
   logic [DW-1:0]  if_rdata_o;
   logic           if_ack_o, if_err_o;
   logic           mem_req, mem_we;
   logic [3:0]     mem_sel;
   logic [AW-1:0]  mem_addr;
   logic [DW-1:0]  mem_wdata;
   logic [DW-1:0]  mem_rdata_o;
   logic           mem_ack_o, mem_err_o;
   logic           bus_cyc_o, bus_stb_o, bus_we_o;
   logic [3:0]     bus_sel_o;
   logic [AW-1:0]  bus_addr_o;
   logic [DW-1:0]  bus_wdata_o;
   logic [DW-1:0]  bus_rdata_i;
   logic           bus_ack_i;
   logic           if_stall_o, mem_stall_o;

   int checks   = 0;
   int failures = 0;

   // reference model state
   bit            last_was_if = 1'b1;  // after reset MEM is favoured
   logic [DW-1:0] last_if_rd  = '0;
   logic [DW-1:0] last_mem_rd = '0;

   mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .if_req_i    (if_req),
      .if_addr_i   (if_addr),
      .if_rdata_o  (if_rdata_o),
      .if_ack_o    (if_ack_o),
      .if_err_o    (if_err_o),
      .mem_req_i   (mem_req),
      .mem_we_i    (mem_we),
      .mem_sel_i   (mem_sel),
      .mem_addr_i  (mem_addr),
      .mem_wdata_i (mem_wdata),
      .mem_rdata_o (mem_rdata_o),
      .mem_ack_o   (mem_ack_o),
      .mem_err_o   (mem_err_o),
      .bus_cyc_o   (bus_cyc_o),
      .bus_stb_o   (bus_stb_o),
      .bus_we_o    (bus_we_o),
      .bus_sel_o   (bus_sel_o),
      .bus_addr_o  (bus_addr_o),
      .bus_wdata_o (bus_wdata_o),
      .bus_rdata_i (bus_rdata_i),
      .bus_ack_i   (bus_ack_i),
      .if_stall_o  (if_stall_o),
      .mem_stall_o (mem_stall_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Arbitration rule: a lone request wins; on a tie MEM wins (fixed) or the
   // requester that did not win last time wins (round robin).
   function automatic bit pick_mem(input logic m, input logic i);
`ifdef ARB_RR_EN
      if (m && i) return last_was_if;
`endif
      return m;
   endfunction

   task automatic do_reset();
      @(posedge clk); #1;
      rst_i   = 1'b0;
      if_req  = 1'b0;
      mem_req = 1'b0;
      bus_ack_i = 1'b0;
      #1;
      chk("rst_bus", {bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o}, '0);
      chk("rst_ackerr", {if_ack_o, if_err_o, mem_ack_o, mem_err_o}, '0);
      chk("rst_rdata", {if_rdata_o, mem_rdata_o}, '0);
      @(posedge clk); #1;
      rst_i       = 1'b1;
      last_was_if = 1'b1;
      last_if_rd  = '0;
      last_mem_rd = '0;
   endtask

   // Runs one access starting in an IDLE cycle with the requests already driven.
   // wt = slave wait states after stb; wt >= TO means the slave never answers.
   task automatic access(input int wt, input logic [DW-1:0] rd, input bit drop,
                         output bit own_mem, output bit got_mem_ack);
      logic [AW-1:0] e_addr;
      logic          e_we;
      logic [3:0]    e_sel;
      logic [DW-1:0] e_wd;
      bit            fin;
      own_mem     = pick_mem(mem_req, if_req);
      got_mem_ack = 1'b0;
      if (own_mem) begin
         e_addr = mem_addr; e_we = mem_we; e_sel = mem_sel; e_wd = mem_wdata;
      end else begin
         e_addr = if_addr;  e_we = 1'b0;   e_sel = 4'hF;    e_wd = '0;
      end
      #1;
      chk("idle_cyc", {bus_cyc_o, bus_stb_o}, 2'b00);
      chk("idle_if_stall", if_stall_o, if_req);
      chk("idle_mem_stall", mem_stall_o, mem_req);
      @(posedge clk); #1;
      chk("gnt_addr", bus_addr_o, e_addr);
      chk("gnt_we", bus_we_o, e_we);
      chk("gnt_sel", bus_sel_o, e_sel);
      if (own_mem) chk("gnt_wdata", bus_wdata_o, e_wd);
      fin = 1'b0;
      for (int g = 1; g <= TO && !fin; g++) begin
         if (drop && g == 2) begin
            if (own_mem) mem_req = 1'b0; else if_req = 1'b0;
         end
         bus_ack_i   = (g == wt + 1);
         bus_rdata_i = bus_ack_i ? rd : DW'($urandom);
         #1;
         chk("gnt_stb", {bus_cyc_o, bus_stb_o}, 2'b11);
         if (bus_ack_i) begin
            chk("own_ack", own_mem ? mem_ack_o : if_ack_o, 1'b1);
            chk("own_err_on_ack", own_mem ? mem_err_o : if_err_o, 1'b0);
            chk("own_rdata", own_mem ? mem_rdata_o : if_rdata_o, rd);
            chk("oth_rdata_hold", own_mem ? if_rdata_o : mem_rdata_o,
                own_mem ? last_if_rd : last_mem_rd);
            got_mem_ack = mem_ack_o;
            if (own_mem) last_mem_rd = rd; else last_if_rd = rd;
            fin = 1'b1;
         end else if (g == TO) begin
            chk("own_err", own_mem ? mem_err_o : if_err_o, 1'b1);
            chk("own_ack_on_err", own_mem ? mem_ack_o : if_ack_o, 1'b0);
            fin = 1'b1;
         end else begin
            chk("busy_ackerr", {if_ack_o, if_err_o, mem_ack_o, mem_err_o}, '0);
            chk("busy_stall", own_mem ? mem_stall_o : if_stall_o,
                own_mem ? mem_req : if_req);
         end
         if (fin) begin
            chk("oth_ackerr", own_mem ? {if_ack_o, if_err_o} : {mem_ack_o, mem_err_o}, 2'b00);
            chk("own_stall_end", own_mem ? mem_stall_o : if_stall_o, 1'b0);
         end
         @(posedge clk); #1;
      end
      chk("turn_cyc", {bus_cyc_o, bus_stb_o}, 2'b00);
      chk("turn_ackerr", {if_ack_o, if_err_o, mem_ack_o, mem_err_o}, '0);
      bus_ack_i   = 1'b0;
      last_was_if = !own_mem;
   endtask

   initial begin
      bit om, gm;
      bit exp_seq [4];
      rst_i = 1'b0; if_req = 1'b0; if_addr = '0;
      mem_req = 1'b0; mem_we = 1'b0; mem_sel = '0; mem_addr = '0; mem_wdata = '0;
      bus_ack_i = 1'b0; bus_rdata_i = '0;
`ifdef ARB_RR_EN
      exp_seq[0] = 1'b1; exp_seq[1] = 1'b0; exp_seq[2] = 1'b1; exp_seq[3] = 1'b0;
`else
      exp_seq[0] = 1'b1; exp_seq[1] = 1'b1; exp_seq[2] = 1'b1; exp_seq[3] = 1'b1;
`endif
      do_reset();

      // IF-only read, slave answers two cycles after stb
      if_req = 1'b1; if_addr = 32'h0000_0040;
      access(2, 32'h0000_0013, 1'b0, om, gm);
      chk("t1_if_rdata_hold", if_rdata_o, 32'h0000_0013);
      if_req = 1'b0;

      // MEM byte write, zero-wait slave
      mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'b0100;
      mem_addr = 32'h0000_1000; mem_wdata = 32'h00AB_0000;
      access(0, 32'h0, 1'b0, om, gm);
      mem_req = 1'b0;

      // simultaneous requests held across four zero-wait accesses
      do_reset();
      if_req = 1'b1; if_addr = 32'h0000_2000;
      mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h0000_3000;
      for (int k = 0; k < 4; k++) begin
         access(0, DW'($urandom), 1'b0, om, gm);
         chk("arb_seq", gm, exp_seq[k]);
      end
      if_req = 1'b0; mem_req = 1'b0;

      // watchdog timeout on MEM, then an IF request is served
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_4000;
      access(40, 32'h0, 1'b0, om, gm);
      mem_req = 1'b0;
      if_req = 1'b1; if_addr = 32'h0000_0100;
      access(0, 32'hCAFE_0001, 1'b0, om, gm);
      chk("to_then_if", om, 1'b0);
      if_req = 1'b0;

      // ack on the last allowed cycle wins over the timeout
      mem_req = 1'b1; mem_addr = 32'h0000_5000;
      access(TO - 1, 32'h1234_5678, 1'b0, om, gm);
      mem_req = 1'b0;

      // reset asserted mid-grant abandons the access
      if_req = 1'b1; if_addr = 32'h0000_0080;
      @(posedge clk); #1;
      chk("mid_stb", {bus_cyc_o, bus_stb_o}, 2'b11);
      #1 rst_i = 1'b0;
      #1;
      chk("mid_rst_bus", {bus_cyc_o, bus_stb_o}, 2'b00);
      chk("mid_rst_ackerr", {if_ack_o, if_err_o}, 2'b00);
      if_req = 1'b0; bus_ack_i = 1'b1;
      @(posedge clk); #1;
      rst_i = 1'b1;
      last_was_if = 1'b1; last_if_rd = '0; last_mem_rd = '0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("post_rst_ackerr", {if_ack_o, if_err_o, mem_ack_o, mem_err_o}, '0);
         chk("post_rst_cyc", bus_cyc_o, 1'b0);
         @(posedge clk); #1;
      end
      bus_ack_i = 1'b0;

      // randomized traffic; losers keep their request, winners re-roll
      for (int n = 0; n < 60; n++) begin
         if (!if_req && $urandom_range(0, 3) != 0) begin
            if_req = 1'b1; if_addr = $urandom;
         end
         if (!mem_req && $urandom_range(0, 3) != 0) begin
            mem_req = 1'b1; mem_we = 1'($urandom); mem_sel = 4'($urandom);
            mem_addr = $urandom; mem_wdata = $urandom;
         end
         if (!if_req && !mem_req) begin
            bus_ack_i = 1'b1; bus_rdata_i = $urandom;
            #1;
            chk("idle_ack_ignored", {if_ack_o, mem_ack_o, bus_cyc_o}, 3'b000);
            @(posedge clk); #1;
            chk("idle_stays", bus_cyc_o, 1'b0);
            bus_ack_i = 1'b0;
            continue;
         end
         access($urandom_range(0, 17), DW'($urandom), ($urandom_range(0, 5) == 0), om, gm);
         if (om) mem_req = 1'b0; else if_req = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
